flit_injector: RTL and testbench

Local-port injection stage of the bufferless router, the counterpart of the ejector. It accepts flits from the local core through a valid/ready handshake and buffers them in a small FIFO. It then inserts the head flit into the first empty output slot among the four directional links after ejection. Outputs are registered, so this block is also the pipeline register in front of the permutation/routing stage.

---
 rtl/noc_pkg.sv | 29 ++
 rtl/inject_fifo.sv | 53 +++++
 rtl/flit_injector.sv | 107 ++++++++++
 tb/tb_flit_injector.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : noc_pkg
// Description : Shared flit format and port indices for the bufferless router.
// Revision    : 1.0 - initial release
// ============================================================================
package noc_pkg;

    localparam int FLIT_W    = 10;
    localparam int VALID_BIT = 9;
    localparam int DST_MSB   = 8;
    localparam int DST_LSB   = 5;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [1:0] {
        PORT_N = 2'd0,
        PORT_E = 2'd1,
        PORT_S = 2'd2,
        PORT_W = 2'd3
    } port_e;

    // Only the valid bit decides occupancy; the rest of an empty slot may be X.
    function automatic logic slot_busy(input flit_t f);
        return f[VALID_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/inject_fifo.sv
`default_nettype none
// ============================================================================
// Module      : inject_fifo
// Description : Small synchronous FIFO holding flits waiting for injection.
// Revision    : 1.0 - initial release
// ============================================================================
module inject_fifo
    import noc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  push,
    input  flit_t push_data,
    input  logic  pop,
    output logic  full,
    output logic  empty,
    output flit_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    flit_t         r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (push && !pop)      r_count <= r_count + 1'b1;
            else if (pop && !push) r_count <= r_count - 1'b1;
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= push_data;
    end

    assign full  = (r_count == CW'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/flit_injector.sv
`default_nettype none
// ============================================================================
// Module      : flit_injector
// Description : Local-port injection stage; drops the queued head flit into
//               the first empty link slot (N > E > S > W) and registers slots.
// Revision    : 1.0 - initial release
// ============================================================================
module flit_injector
    import noc_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [9:0]   northad,
    input  logic [9:0]   southad,
    input  logic [9:0]   eastad,
    input  logic [9:0]   westad,
    input  logic         inj_valid,
    input  logic [9:0]   inj_flit,
    output logic         inj_ready,
    output logic [9:0]   nad,
    output logic [9:0]   sad,
    output logic [9:0]   ead,
    output logic [9:0]   wad,
    output logic         starved,
    output logic [15:0]  inj_count
);

    localparam logic [7:0] c_starve_lim = 8'(STARVE_LIMIT);

    logic       w_full;
    logic       w_empty;
    flit_t      w_head;
    flit_t      w_push_data;
    logic       w_push;
    logic       w_inject;
    port_e      w_sel;
    flit_t      w_in  [4];
    flit_t      w_out [4];
    logic [7:0] r_starve;

    assign w_in[PORT_N] = northad;
    assign w_in[PORT_E] = eastad;
    assign w_in[PORT_S] = southad;
    assign w_in[PORT_W] = westad;

    assign inj_ready   = !w_full && !rst;
    assign w_push      = inj_valid && inj_ready;
    assign w_push_data = {1'b1, inj_flit[DST_MSB:0]};

    inject_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_inject),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    always_comb begin
        w_inject = 1'b0;
        w_sel    = PORT_N;
        w_out    = w_in;
        if (!w_empty) begin
            if (!slot_busy(w_in[PORT_N])) begin
                w_sel = PORT_N; w_inject = 1'b1;
            end else if (!slot_busy(w_in[PORT_E])) begin
                w_sel = PORT_E; w_inject = 1'b1;
            end else if (!slot_busy(w_in[PORT_S])) begin
                w_sel = PORT_S; w_inject = 1'b1;
            end else if (!slot_busy(w_in[PORT_W])) begin
                w_sel = PORT_W; w_inject = 1'b1;
            end
        end
        if (w_inject) w_out[w_sel] = w_head;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nad       <= '0;
            sad       <= '0;
            ead       <= '0;
            wad       <= '0;
            inj_count <= '0;
            r_starve  <= '0;
        end else begin
            nad <= w_out[PORT_N];
            ead <= w_out[PORT_E];
            sad <= w_out[PORT_S];
            wad <= w_out[PORT_W];
            if (w_inject) inj_count <= inj_count + 16'd1;
            // Count only cycles where a flit is waiting and every slot is taken.
            if (w_empty || w_inject)          r_starve <= '0;
            else if (r_starve != c_starve_lim) r_starve <= r_starve + 8'd1;
        end
    end

    assign starved = (r_starve == c_starve_lim);

endmodule
`default_nettype wire

// File: tb/tb_flit_injector.sv
`default_nettype none
// ============================================================================
// Module      : tb_flit_injector
// Description : Randomised scoreboard bench for flit_injector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_flit_injector;

    localparam int DEPTH = 4;
    localparam int LIMIT = 15;

    logic        clk;
    logic        rst;
    logic [9:0]  northad, southad, eastad, westad;
    logic        inj_valid;
    logic [9:0]  inj_flit;
    logic        inj_ready;
    logic [9:0]  nad, sad, ead, wad;
    logic        starved;
    logic [15:0] inj_count;

    flit_injector #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .northad   (northad),
        .southad   (southad),
        .eastad    (eastad),
        .westad    (westad),
        .inj_valid (inj_valid),
        .inj_flit  (inj_flit),
        .inj_ready (inj_ready),
        .nad       (nad),
        .sad       (sad),
        .ead       (ead),
        .wad       (wad),
        .starved   (starved),
        .inj_count (inj_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0]  n, e, s, w;
        logic [15:0] cnt;
        logic        st;
    } exp_t;

    exp_t        exp_q[$];
    logic [9:0]  mq[$];
    int          streak;
    logic [15:0] mcount;
    int          total;
    int          bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    // Reference: a flit queue, first-empty-slot insertion, and a blocked-cycle streak.
    task automatic apply(input logic v, input logic [9:0] f,
                         input logic [9:0] n, input logic [9:0] e,
                         input logic [9:0] s, input logic [9:0] w);
        logic [9:0] sl [4];
        exp_t       x;
        bit         inj;
        int         sz;
        inj_valid = v; inj_flit = f;
        northad = n; eastad = e; southad = s; westad = w;
        #1;
        sz = mq.size();
        chk("inj_ready", 32'(inj_ready), 32'(sz < DEPTH));
        sl[0] = n; sl[1] = e; sl[2] = s; sl[3] = w;
        inj = 0;
        if (sz > 0) begin
            for (int p = 0; p < 4; p++) begin
                if (!inj && sl[p][9] !== 1'b1) begin
                    sl[p] = mq[0];
                    inj = 1;
                end
            end
        end
        if (inj) void'(mq.pop_front());
        streak = (sz > 0 && !inj) ? streak + 1 : 0;
        if (inj) mcount = mcount + 16'd1;
        if (v && sz < DEPTH) mq.push_back({1'b1, f[8:0]});
        x.n = sl[0]; x.e = sl[1]; x.s = sl[2]; x.w = sl[3];
        x.cnt = mcount;
        x.st  = (streak >= LIMIT);
        exp_q.push_back(x);
    endtask

    task automatic step(input logic v, input logic [9:0] f,
                        input logic [9:0] n, input logic [9:0] e,
                        input logic [9:0] s, input logic [9:0] w);
        @(negedge clk);
        apply(v, f, n, e, s, w);
    endtask

    function automatic logic [9:0] vf();
        return 10'h200 | 10'($urandom);
    endfunction

    function automatic logic [9:0] rslot();
        return ($urandom_range(3) != 0) ? vf() : 10'($urandom) & 10'h1FF;
    endfunction

    task automatic do_reset_mid();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_nad", 32'(nad), 32'h0);
        chk("rst_sad", 32'(sad), 32'h0);
        chk("rst_ead", 32'(ead), 32'h0);
        chk("rst_wad", 32'(wad), 32'h0);
        chk("rst_cnt", 32'(inj_count), 32'h0);
        chk("rst_starved", 32'(starved), 32'h0);
        chk("rst_ready", 32'(inj_ready), 32'h0);
        mq.delete();
        streak = 0;
        mcount = '0;
        inj_valid = 1'b0;
        northad = '0; eastad = '0; southad = '0; westad = '0;
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);
    endtask

    // Monitor: compare registered outputs one cycle after each issued stimulus.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("nad", 32'(nad), 32'(x.n));
                chk("ead", 32'(ead), 32'(x.e));
                chk("sad", 32'(sad), 32'(x.s));
                chk("wad", 32'(wad), 32'(x.w));
                chk("inj_count", 32'(inj_count), 32'(x.cnt));
                chk("starved", 32'(starved), 32'(x.st));
            end
        end
    end

    initial begin
        logic [9:0] a, b, c;
        total = 0; bad = 0; streak = 0; mcount = '0;
        rst = 1'b1;
        inj_valid = 1'b0; inj_flit = '0;
        northad = '0; eastad = '0; southad = '0; westad = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_nad", 32'(nad), 32'h0);
        chk("init_sad", 32'(sad), 32'h0);
        chk("init_ead", 32'(ead), 32'h0);
        chk("init_wad", 32'(wad), 32'h0);
        chk("init_cnt", 32'(inj_count), 32'h0);
        chk("init_starved", 32'(starved), 32'h0);
        chk("init_ready", 32'(inj_ready), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        apply(1'b0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);

        // Single push into an idle router lands on north two cycles later.
        step(1'b1, 10'h0A5, 10'h0, 10'h0, 10'h0, 10'h0);
        repeat (3) step(1'b0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);

        // North busy, east free: head goes east; then an all-busy wait.
        step(1'b1, 10'h031, 10'h224, 10'h0, 10'h0, 10'h0);
        step(1'b0, 10'h0, 10'h224, 10'h0, 10'h0, 10'h0);
        step(1'b1, 10'h1C7, vf(), vf(), vf(), vf());
        repeat (3) step(1'b0, 10'h0, vf(), vf(), vf(), vf());
        // Empty slot whose non-valid bits are unknown still counts as empty.
        step(1'b0, 10'h0, {1'b0, 9'bx}, vf(), vf(), vf());

        // Fill the FIFO under full blocking, starve, then free west.
        repeat (22) step(1'b1, 10'($urandom), vf(), vf(), vf(), vf());
        step(1'b1, 10'($urandom), vf(), vf(), vf(), 10'h0);
        repeat (8) step(1'b0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);

        // Streaming through south across several pointer wraps.
        repeat (3 * DEPTH + 4) step(1'b1, 10'($urandom), vf(), vf(), 10'h0, vf());
        repeat (6) step(1'b0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1'($urandom), 10'($urandom), rslot(), rslot(), rslot(), rslot());

        // Queue three flits with every slot valid, then reset asynchronously.
        repeat (6) step(1'b0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);
        a = vf(); b = vf(); c = vf();
        repeat (3) step(1'b1, 10'($urandom), a, b, c, vf());
        step(1'b0, 10'h0, a, b, c, vf());
        do_reset_mid();
        repeat (4) step(1'b0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);

        // Drive inj_count through its wrap point.
        do_reset_mid();
        repeat (65538) step(1'b1, 10'($urandom), 10'h0, 10'h0, 10'h0, 10'h0);
        repeat (3) step(1'b0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);

        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
